// File: rtl/tx_gearbox_if.sv
// Handshake bundle between a 64b/66b encoder and tx_gearbox.
// slave: the gearbox side. master: the payload source / line sink side.
// TX_GEARBOX_ERR_EN adds the o_protocol_err output.
interface tx_gearbox_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_data_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_hdr_valid;
  logic [1:0]            i_hdr;
  logic                  o_ready;
  logic                  o_data_valid;
  logic [DATA_WIDTH-1:0] o_data;
`ifdef TX_GEARBOX_ERR_EN
  logic                  o_protocol_err;

  modport slave (
    input  i_data_valid, i_data, i_hdr_valid, i_hdr,
    output o_ready, o_data_valid, o_data, o_protocol_err
  );
  modport master (
    output i_data_valid, i_data, i_hdr_valid, i_hdr,
    input  o_ready, o_data_valid, o_data, o_protocol_err
  );
`else
  modport slave (
    input  i_data_valid, i_data, i_hdr_valid, i_hdr,
    output o_ready, o_data_valid, o_data
  );
  modport master (
    output i_data_valid, i_data, i_hdr_valid, i_hdr,
    input  o_ready, o_data_valid, o_data
  );
`endif
endinterface

// File: rtl/tx_gearbox.sv
// 66b -> 32b transmit gearbox. Each accepted word appends its optional 2-bit
// sync header and 32 payload bits (bit 0 first) to a bit buffer; 32 bits are
// emitted, registered, whenever the buffer holds at least 32. Every 32 accepted
// words (16 blocks) the buffer holds an extra 32 bits, drained in a pause
// cycle (seq == 32) during which o_ready is low.
// Optional: define TX_GEARBOX_ERR_EN to add o_protocol_err.
module tx_gearbox #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  tx_gearbox_if.slave  bus
);

  // Worst case: 32 bits left over plus a 34-bit header+payload append.
  localparam int unsigned BufW     = 2 * DATA_WIDTH + 2;
  localparam logic [5:0]  SeqPause = 6'(DATA_WIDTH);
  localparam logic [6:0]  WordLen  = 7'(DATA_WIDTH);

  logic [BufW-1:0]       bit_buf_q, bit_buf_d;
  logic [6:0]            fill_q, fill_d;
  logic [5:0]            seq_q, seq_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  ready;
  logic                  accept;
  logic                  pause;
  logic [BufW-1:0]       ins_bits;
  logic [6:0]            ins_len;
  logic [6:0]            fill_sum;
  logic [BufW-1:0]       merged;

  assign ready  = (seq_q != SeqPause);
  assign pause  = ~ready;
  assign accept = bus.i_data_valid & ready;

  // New bits land just above the current fill, so older bits stay at the bottom.
  assign ins_bits = bus.i_hdr_valid ?
                    {{(BufW - DATA_WIDTH - 2){1'b0}}, bus.i_data, bus.i_hdr} :
                    {{(BufW - DATA_WIDTH){1'b0}}, bus.i_data};
  assign ins_len  = bus.i_hdr_valid ? (WordLen + 7'd2) : WordLen;
  assign fill_sum = fill_q + ins_len;
  assign merged   = bit_buf_q | (ins_bits << fill_q);

  // Next-state: pause drain, accept/append/emit, or hold.
  always_comb begin
    bit_buf_d   = bit_buf_q;
    fill_d      = fill_q;
    seq_d       = seq_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (pause) begin
      out_data_d  = bit_buf_q[DATA_WIDTH-1:0];
      out_valid_d = 1'b1;
      bit_buf_d   = '0;
      fill_d      = '0;
      seq_d       = '0;
    end else if (accept) begin
      seq_d = seq_q + 6'd1;
      if (fill_sum >= WordLen) begin
        out_data_d  = merged[DATA_WIDTH-1:0];
        out_valid_d = 1'b1;
        bit_buf_d   = merged >> DATA_WIDTH;
        fill_d      = fill_sum - WordLen;
      end else begin
        bit_buf_d = merged;
        fill_d    = fill_sum;
      end
    end
  end

  // State and output registers; reset clears all partial data immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_buf_q   <= '0;
      fill_q      <= '0;
      seq_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      bit_buf_q   <= bit_buf_d;
      fill_q      <= fill_d;
      seq_q       <= seq_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_data_valid = out_valid_q;
  assign bus.o_data       = out_data_q;

`ifdef TX_GEARBOX_ERR_EN
  logic err_q, err_d;

  // Flag writes during the pause and headers off the even-word alternation.
  always_comb begin
    err_d = (bus.i_data_valid & ~ready) |
            (accept & (bus.i_hdr_valid != ~seq_q[0]));
  end

  // One-cycle registered error pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.o_protocol_err = err_q;
`else
  // No protocol checking in this build.
`endif

endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox: a bit-queue model predicts every output each cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tx_gearbox;

  logic i_clk;
  logic i_reset_n;

  tx_gearbox_if #(.DATA_WIDTH(32)) bus ();

  tx_gearbox #(.DATA_WIDTH(32)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a plain queue of line bits, oldest at the front.
  bit          mq[$];
  int          mseq;
  logic [31:0] exp_data;
  logic        exp_valid;
  logic        exp_err;

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mq.delete();
      mseq      = 0;
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (mseq == 32) begin
        exp_data = '0;
        for (int i = 0; i < 32; i++) if (mq.size() > 0) exp_data[i] = mq.pop_front();
        mq.delete();
        exp_valid = 1'b1;
        exp_err   = bus.i_data_valid;
        mseq      = 0;
      end else if (bus.i_data_valid) begin
        if (bus.i_hdr_valid) begin
          mq.push_back(bus.i_hdr[0]);
          mq.push_back(bus.i_hdr[1]);
        end
        for (int i = 0; i < 32; i++) mq.push_back(bus.i_data[i]);
        exp_err = (bus.i_hdr_valid != (mseq % 2 == 0));
        mseq++;
        if (mq.size() >= 32) begin
          for (int i = 0; i < 32; i++) exp_data[i] = mq.pop_front();
          exp_valid = 1'b1;
        end
      end
    end
  end

  // Compare process: mid-cycle, away from the active edge.
  always @(negedge i_clk) begin
    check("ready", 32'(bus.o_ready), 32'(mseq != 32));
    check("valid", 32'(bus.o_data_valid), 32'(exp_valid));
    check("data", bus.o_data, exp_data);
`ifdef TX_GEARBOX_ERR_EN
    check("err", 32'(bus.o_protocol_err), 32'(exp_err));
`endif
  end

  task automatic cycle(input logic dv, input logic [31:0] d, input logic hv,
                       input logic [1:0] h);
    bus.i_data_valid = dv;
    bus.i_data       = d;
    bus.i_hdr_valid  = hv;
    bus.i_hdr        = h;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    bus.i_hdr_valid  = 1'b0;
    bus.i_hdr        = '0;
    i_reset_n = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  int n_ready_low;
  int ready_low_idx;
  int n_valid;

  initial begin
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    bus.i_hdr_valid  = 1'b0;
    bus.i_hdr        = '0;
    i_reset_n = 1'b1;
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_data", bus.o_data, 32'h0);
    check("rst_valid", 32'(bus.o_data_valid), 32'h0);
    check("rst_ready", 32'(bus.o_ready), 32'h1);
    do_reset();

    // Header 01 + zero payload: first line word is 1.
    cycle(1'b1, 32'h0, 1'b1, 2'b01);
    check("first_word", bus.o_data, 32'h0000_0001);
    check("first_valid", 32'(bus.o_data_valid), 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 2'b00);

    // Header 10 + all ones, then the two leftover ones lead the next word.
    do_reset();
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 2'b10);
    check("hdr10_word", bus.o_data, 32'hFFFF_FFFE);
    cycle(1'b1, 32'h1234_5678, 1'b0, 2'b00);
    check("carry_word", bus.o_data, 32'h48D1_59E3);
    cycle(1'b1, 32'h0, 1'b1, 2'b11);
    check("carry_word2", bus.o_data, 32'h0000_000C);
    cycle(1'b0, 32'h0, 1'b0, 2'b00);

    // 16 contiguous blocks, then a write attempt during the pause cycle.
    do_reset();
    n_ready_low   = 0;
    ready_low_idx = -1;
    n_valid       = 0;
    for (int i = 0; i < 33; i++) begin
      logic [31:0] w;
      w = 32'h9E37_79B9 * 32'(i + 1);
      if (!bus.o_ready) begin
        n_ready_low++;
        ready_low_idx = i;
      end
      if (i == 32) cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00);
      else cycle(1'b1, w, (i % 2 == 0), (i % 4 == 0) ? 2'b01 : 2'b10);
      if (bus.o_data_valid) n_valid++;
    end
`ifdef TX_GEARBOX_ERR_EN
    check("pause_err", 32'(bus.o_protocol_err), 32'h1);
`endif
    check("ready_low_count", 32'(n_ready_low), 32'd1);
    check("ready_low_cycle", 32'(ready_low_idx), 32'd32);
    check("valid_run", 32'(n_valid), 32'd33);
    cycle(1'b0, 32'h0, 1'b0, 2'b00);
    check("post_pause_valid", 32'(bus.o_data_valid), 32'h0);
    check("post_pause_ready", 32'(bus.o_ready), 32'h1);
`ifdef TX_GEARBOX_ERR_EN
    check("err_pulse_end", 32'(bus.o_protocol_err), 32'h0);
`endif
    // Buffer empty and seq at 0: a fresh block starts cleanly.
    cycle(1'b1, 32'h0, 1'b1, 2'b01);
    check("after_drain", bus.o_data, 32'h0000_0001);
    cycle(1'b0, 32'h0, 1'b0, 2'b00);

    // Five idle cycles mid-stream leave the bit order intact.
    do_reset();
    cycle(1'b1, 32'h0, 1'b1, 2'b01);
    cycle(1'b1, 32'hC000_0000, 1'b0, 2'b00);
    check("pre_idle", bus.o_data, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'hFFFF_FFFF, 1'b1, 2'b11);
      check("idle_valid", 32'(bus.o_data_valid), 32'h0);
      check("idle_hold", bus.o_data, 32'h0000_0000);
    end
    cycle(1'b1, 32'h0, 1'b1, 2'b10);
    check("post_idle", bus.o_data, 32'h0000_000B);
    cycle(1'b0, 32'h0, 1'b0, 2'b00);

    // Asynchronous reset at seq 17, then a fresh stream.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 32'hA5A5_0000 + 32'(i), (i % 2 == 0), (i % 4 == 0) ? 2'b01 : 2'b10);
    end
    #3 i_reset_n = 1'b0;
    #1;
    check("async_data", bus.o_data, 32'h0);
    check("async_valid", 32'(bus.o_data_valid), 32'h0);
    check("async_ready", 32'(bus.o_ready), 32'h1);
    bus.i_data_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    cycle(1'b1, 32'h0, 1'b1, 2'b01);
    check("post_reset_word", bus.o_data, 32'h0000_0001);
    check("post_reset_valid", 32'(bus.o_data_valid), 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 2'b00);
    cycle(1'b0, 32'h0, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_gearbox.md
TX_GEARBOX -- requirements
Module: tx_gearbox

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, the input and output word width in bits; only 32 is supported.
REQ-002 SHALL provide port i_clk  input  1  sole clock; all state is updated on its rising edge.
REQ-003 SHALL provide port i_reset_n  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL provide port i_data_valid  input  1  scrambled payload word present.
REQ-005 SHALL provide port i_data  input  32  scrambled payload word; bit 0 is transmitted first.
REQ-006 SHALL provide port i_hdr_valid  input  1  marks the first payload word of a 66-bit block.
REQ-007 SHALL provide port i_hdr  input  2  sync header, sampled when i_hdr_valid is high; bit 0 is transmitted first.
REQ-008 SHALL provide port o_ready  output  1  gearbox can accept a word this cycle.
REQ-009 SHALL provide port o_data_valid  output  1  o_data holds a valid line word.
REQ-010 SHALL provide port o_data  output  32  line word to the transceiver; bit 0 is the oldest bit.

Function
REQ-011 SHALL accept a word only when i_data_valid and o_ready are both high in the same cycle.
REQ-012 SHALL keep an internal bit buffer and a fill count; an accepted word appends i_hdr (when i_hdr_valid) followed by i_data, preserving bit order.
REQ-013 SHALL emit the oldest 32 buffered bits one cycle after acceptance when the post-append fill is at least 32, and assert o_data_valid for that cycle.
REQ-014 SHALL otherwise hold o_data at its previous value and drive o_data_valid low.
REQ-015 SHALL keep a sequence counter seq over 0..32 that increments on each accepted word, wraps 32 to 0, and stays frozen while no word is accepted and seq is not 32.
REQ-016 SHALL drive o_ready combinationally as (seq != 32).
REQ-017 In the seq==32 pause cycle, SHALL accept no input, drain 32 buffered bits with o_data_valid high, bring the fill to 0, and set seq to 0.
REQ-018 SHALL never let the fill exceed 66 bits under legal stimulus: 16 blocks in, 32 accepted words in, 33 words out.
REQ-019 SHALL discard a word presented while o_ready is low, leaving the buffer, fill and seq unchanged.
REQ-020 SHALL append the header on whatever accepted word carries i_hdr_valid, with no alignment correction.

Reset
REQ-021 While i_reset_n is low, SHALL immediately, without a clock edge, force o_data=0, o_data_valid=0, fill=0, seq=0 and the buffer to 0, giving o_ready=1.
REQ-022 A reset asserted mid-block SHALL discard all partial data; the first accepted word after release SHALL be treated as new data.

Configuration
REQ-023 With macro TX_GEARBOX_ERR_EN defined, SHALL add output o_protocol_err (1 bit, reset 0), registered and pulsed high for one cycle on either of:
- i_data_valid while o_ready is low;
- an accepted word whose i_hdr_valid does not match the expected alternation (header on the even word of each block).
REQ-024 Without TX_GEARBOX_ERR_EN, o_protocol_err and its checking logic SHALL be absent; data-path behaviour SHALL be identical in both builds.

Verification
REQ-025 Reset, then hdr=2'b01 with i_data=0 on a block start -> the next cycle gives o_data=32'h00000001 with o_data_valid=1.
REQ-026 hdr=2'b10 then i_data=32'hFFFFFFFF -> first o_data=32'hFFFFFFFE; the next block's output starts with two 1 bits at bits [1:0].
REQ-027 Stream 16 contiguous blocks -> o_ready low exactly once, in the 33rd cycle; 33 consecutive o_data_valid=1 words; seq reads 0 afterwards.
REQ-028 Assert i_data_valid during the pause cycle with word 32'hDEADBEEF -> the word is absent from the output stream; with the macro, o_protocol_err=1 for one cycle.
REQ-029 Hold i_data_valid low for 5 cycles mid-block -> o_data_valid=0 and seq frozen for those cycles; output bit order unchanged.
REQ-030 Assert i_reset_n low asynchronously at seq=17 -> outputs are 0 and o_ready=1 before the next edge; a fresh stream then reproduces REQ-025.
